lcd_bus_engine: RTL and testbench

LCD_BUS_ENGINE -- requirements
Module: lcd_bus_engine

---
 rtl/common_pkg.sv | 30 +++
 rtl/lcd_cmd_fifo.sv | 46 ++++
 rtl/lcd_bus_engine.sv | 198 +++++++++++++++++++
 tb/tb_lcd_bus_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types for the LCD bus engine: FSM states, the queued command and
// a helper for sizing the timing counters.
package common_pkg;

  localparam int unsigned CMD_W = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_EHI   = 3'd2,
    W_ELO   = 3'd3,
    P_SETUP = 3'd4,
    P_EHI   = 3'd5,
    P_ELO   = 3'd6,
    P_CHK   = 3'd7
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO holding {rs,data} entries; power-of-two depth, pointers carry
// an extra wrap bit so full and empty are distinguishable.
module lcd_cmd_fifo
  import common_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [CMD_W-1:0] din_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/lcd_bus_engine.sv
// HD44780-style bus engine: pops queued commands, writes them as one byte or
// two nibbles, then polls the busy flag until clear or a timeout expires.
module lcd_bus_engine
  import common_pkg::*;
#(
  parameter int unsigned BUS_W            = 4,
  parameter int unsigned SETUP_CYC        = 2,
  parameter int unsigned E_PULSE_CYC      = 4,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned BUSY_TIMEOUT_CYC = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             i_valid,
  input  logic             i_rs,
  input  logic [7:0]       i_data,
  output logic             o_ready,
  inout  wire  [BUS_W-1:0] io_LCD_data,
  output logic             o_E,
  output logic             o_RW,
  output logic             o_RS,
  output logic             o_idle,
  output logic             o_timeout
);

  localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, E_PULSE_CYC, BUSY_TIMEOUT_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(BUSY_TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               NIBBLE_MODE = (BUS_W == 4);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic             nib_q, nib_d;
  logic             busy_q, busy_d;
  lcd_cmd_t         cmd_q, cmd_d;
  logic             e_q, e_d, rw_q, rw_d, rs_q, rs_d;
  logic             drv_q, drv_d, timeout_q, timeout_d;
  logic [BUS_W-1:0] bus_q, bus_d;

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  logic [CNT_W-1:0] phase_last;
  logic             phase_done, write_st, poll_st;
  logic             bus_unused;

  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .push_i (i_valid),
    .din_i  ({i_rs, i_data}),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign o_ready     = !fifo_full;
  assign o_idle      = fifo_empty && (state_q == IDLE);
  assign o_E         = e_q;
  assign o_RW        = rw_q;
  assign o_RS        = rs_q;
  assign o_timeout   = timeout_q;
  assign io_LCD_data = drv_q ? bus_q : {BUS_W{1'bz}};
  // Only the MSB carries the busy flag; the remaining read bits are ignored.
  assign bus_unused  = ^io_LCD_data;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      nib_q     <= 1'b0;
      busy_q    <= 1'b0;
      cmd_q     <= '0;
      e_q       <= 1'b0;
      rw_q      <= 1'b0;
      rs_q      <= 1'b0;
      drv_q     <= 1'b0;
      bus_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      nib_q     <= nib_d;
      busy_q    <= busy_d;
      cmd_q     <= cmd_d;
      e_q       <= e_d;
      rw_q      <= rw_d;
      rs_q      <= rs_d;
      drv_q     <= drv_d;
      bus_q     <= bus_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; nib_q selects the second nibble (writes) or dummy read (polls).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    nib_d     = nib_q;
    busy_d    = busy_q;
    cmd_d     = cmd_q;
    fifo_pop  = 1'b0;
    timeout_d = 1'b0;

    phase_last = ((state_q == W_SETUP) || (state_q == P_SETUP)) ? SETUP_LAST : E_LAST;
    phase_done = (cnt_q == phase_last);

    if (state_q inside {P_SETUP, P_EHI, P_ELO, P_CHK}) begin
      to_d = (to_q == CNT_MAX) ? to_q : to_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = lcd_cmd_t'(fifo_dout);
          nib_d    = 1'b0;
          state_d  = W_SETUP;
        end
      end
      W_SETUP, W_EHI, P_SETUP: begin
        cnt_d = phase_done ? '0 : cnt_q + CNT_W'(1);
        if (phase_done) begin
          state_d = (state_q == W_SETUP) ? W_EHI :
                    (state_q == W_EHI)   ? W_ELO : P_EHI;
        end
      end
      W_ELO: begin
        cnt_d = phase_done ? '0 : cnt_q + CNT_W'(1);
        if (phase_done) begin
          if (NIBBLE_MODE && !nib_q) begin
            nib_d   = 1'b1;
            state_d = W_SETUP;
          end else begin
            nib_d   = 1'b0;
            to_d    = '0;
            state_d = P_SETUP;
          end
        end
      end
      P_EHI: begin
        cnt_d = phase_done ? '0 : cnt_q + CNT_W'(1);
        if (phase_done) begin
          if (!nib_q) busy_d = io_LCD_data[BUS_W-1];
          state_d = P_ELO;
        end
      end
      P_ELO: begin
        cnt_d = phase_done ? '0 : cnt_q + CNT_W'(1);
        if (phase_done) begin
          if (NIBBLE_MODE && !nib_q) begin
            nib_d   = 1'b1;
            state_d = P_SETUP;
          end else begin
            nib_d   = 1'b0;
            state_d = P_CHK;
          end
        end
      end
      P_CHK: begin
        cnt_d = '0;
        if (!busy_q) begin
          state_d = IDLE;
        end else if (to_q >= TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = P_SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values are derived from the next state so they register alongside it.
  always_comb begin
    write_st = (state_d == W_SETUP) || (state_d == W_EHI) || (state_d == W_ELO);
    poll_st  = (state_d == P_SETUP) || (state_d == P_EHI) ||
               (state_d == P_ELO)   || (state_d == P_CHK);
    e_d      = (state_d == W_EHI) || (state_d == P_EHI);
    rw_d     = poll_st;
    rs_d     = write_st && cmd_d.rs;
    drv_d    = write_st;
    if (NIBBLE_MODE) begin
      bus_d = BUS_W'(nib_d ? cmd_d.data[3:0] : cmd_d.data[7:4]);
    end else begin
      bus_d = BUS_W'(cmd_d.data);
    end
  end

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Directed bench for lcd_bus_engine: a 4-bit and an 8-bit instance, each with
// a small LCD model answering busy-flag reads.
module tb_lcd_bus_engine;

  logic       sys_clk = 1'b0;
  logic       rst_n4, rst_n8;
  logic       i_valid4, i_rs4, i_valid8, i_rs8;
  logic [7:0] i_data4, i_data8;
  logic       o_ready4, o_E4, o_RW4, o_RS4, o_idle4, o_timeout4;
  logic       o_ready8, o_E8, o_RW8, o_RS8, o_idle8, o_timeout8;
  wire  [3:0] bus4;
  wire  [7:0] bus8;

  int checks = 0;
  int errors = 0;

  // LCD model state
  logic busy4;
  int   busy_polls4 = 0;
  logic stuck4 = 1'b0;
  int   base4 = 0;
  int   wr_log4[$];
  int   wr_log8[$];
  int   rdp4 = 0, rdp8 = 0, badlen4 = 0, badlen8 = 0;
  int   run4 = 0, run8 = 0, to_pulses4 = 0, trun4 = 0, to_max4 = 0;
  logic pe4 = 1'b0, pe8 = 1'b0, pt4 = 1'b0;

  always #5 sys_clk = ~sys_clk;

  always_comb busy4 = stuck4 || (((rdp4 - base4) / 2) < busy_polls4);

  assign bus4 = o_RW4 ? {busy4, 3'b000} : 4'bzzzz;
  assign bus8 = o_RW8 ? 8'h00 : 8'hzz;

  lcd_bus_engine #(.BUS_W(4)) u_dut4 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n4), .i_valid(i_valid4), .i_rs(i_rs4),
    .i_data(i_data4), .o_ready(o_ready4), .io_LCD_data(bus4), .o_E(o_E4),
    .o_RW(o_RW4), .o_RS(o_RS4), .o_idle(o_idle4), .o_timeout(o_timeout4)
  );

  lcd_bus_engine #(.BUS_W(8)) u_dut8 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n8), .i_valid(i_valid8), .i_rs(i_rs8),
    .i_data(i_data8), .o_ready(o_ready8), .io_LCD_data(bus8), .o_E(o_E8),
    .o_RW(o_RW8), .o_RS(o_RS8), .o_idle(o_idle8), .o_timeout(o_timeout8)
  );

  // Pulse monitor: logs {rs,bus} at each write E rise, counts read pulses,
  // E-high runs that are not 4 cycles long, and timeout pulses.
  always @(negedge sys_clk) begin
    if (o_E4 && !pe4 && !o_RW4) wr_log4.push_back(int'({o_RS4, 4'h0, bus4}));
    if (o_E4) run4++;
    else if (pe4) begin
      if (run4 != 4) badlen4++;
      if (o_RW4) rdp4++;
      run4 = 0;
    end
    if (o_timeout4) begin
      if (!pt4) to_pulses4++;
      trun4++;
      if (trun4 > to_max4) to_max4 = trun4;
    end else trun4 = 0;
    pe4 = o_E4;
    pt4 = o_timeout4;

    if (o_E8 && !pe8 && !o_RW8) wr_log8.push_back(int'({o_RS8, bus8}));
    if (o_E8) run8++;
    else if (pe8) begin
      if (run8 != 4) badlen8++;
      if (o_RW8) rdp8++;
      run8 = 0;
    end
    pe8 = o_E8;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push4(input logic rs, input logic [7:0] d, output int held);
    held = 0;
    i_valid4 = 1'b1; i_rs4 = rs; i_data4 = d;
    while (!o_ready4 && held < 1000) begin
      @(negedge sys_clk);
      held++;
    end
    if (!o_ready4) check("push4_stall", 32'(o_ready4), 32'd1);
    @(negedge sys_clk);
    i_valid4 = 1'b0;
  endtask

  task automatic push8(input logic rs, input logic [7:0] d);
    i_valid8 = 1'b1; i_rs8 = rs; i_data8 = d;
    @(negedge sys_clk);
    i_valid8 = 1'b0;
  endtask

  task automatic wait_idle4(input int budget, input string tag);
    int n = 0;
    while (!o_idle4 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, 32'(o_idle4), 32'd1);
  endtask

  task automatic wait_idle8(input int budget, input string tag);
    int n = 0;
    while (!o_idle8 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, 32'(o_idle8), 32'd1);
  endtask

  initial begin
    int n0, r0, t0, b0, held, k;
    int exp_bytes[6];
    i_valid4 = 1'b0; i_rs4 = 1'b0; i_data4 = 8'h00;
    i_valid8 = 1'b0; i_rs8 = 1'b0; i_data8 = 8'h00;
    rst_n4 = 1'b0; rst_n8 = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Reset state: {E,RW,RS,timeout,ready,idle}
    check("rst4_outs", 32'({o_E4, o_RW4, o_RS4, o_timeout4, o_ready4, o_idle4}), 32'b000011);
    check("rst8_outs", 32'({o_E8, o_RW8, o_RS8, o_timeout8, o_ready8, o_idle8}), 32'b000011);
    rst_n4 = 1'b1; rst_n8 = 1'b1;
    @(negedge sys_clk);

    // Single data write 0x41 in nibble mode, LCD ready immediately
    n0 = wr_log4.size(); r0 = rdp4; t0 = to_pulses4; b0 = badlen4;
    push4(1'b1, 8'h41, held);
    wait_idle4(400, "t1_idle");
    check("t1_wr_cnt", 32'(wr_log4.size() - n0), 32'd2);
    check("t1_nib_hi", 32'(wr_log4[n0]), 32'h104);
    check("t1_nib_lo", 32'(wr_log4[n0+1]), 32'h101);
    check("t1_rd_pulses", 32'(rdp4 - r0), 32'd2);
    check("t1_e_len", 32'(badlen4 - b0), 32'd0);
    check("t1_no_timeout", 32'(to_pulses4 - t0), 32'd0);

    // 8-bit bus: instruction 0x38 in one pulse, one read pulse
    n0 = wr_log8.size(); r0 = rdp8; b0 = badlen8;
    push8(1'b0, 8'h38);
    wait_idle8(400, "t2_idle");
    check("t2_wr_cnt", 32'(wr_log8.size() - n0), 32'd1);
    check("t2_byte", 32'(wr_log8[n0]), 32'h038);
    check("t2_rd_pulses", 32'(rdp8 - r0), 32'd1);
    check("t2_e_len", 32'(badlen8 - b0), 32'd0);

    // Busy for the first two polls: three polls (six read pulses), no timeout
    base4 = rdp4; busy_polls4 = 2;
    n0 = wr_log4.size(); r0 = rdp4; t0 = to_pulses4;
    push4(1'b0, 8'h01, held);
    wait_idle4(600, "t3_idle");
    busy_polls4 = 0;
    check("t3_rd_pulses", 32'(rdp4 - r0), 32'd6);
    check("t3_no_timeout", 32'(to_pulses4 - t0), 32'd0);
    check("t3_wr_cnt", 32'(wr_log4.size() - n0), 32'd2);

    // Busy stuck: four polls then timeout; next entry then transfers
    stuck4 = 1'b1;
    n0 = wr_log4.size(); r0 = rdp4; t0 = to_pulses4;
    push4(1'b1, 8'hAA, held);
    push4(1'b0, 8'h5C, held);
    k = 0;
    while (!o_timeout4 && k < 600) begin
      @(negedge sys_clk);
      k++;
    end
    check("t4_timeout_seen", 32'(o_timeout4), 32'd1);
    check("t4_bus_idle_at_to", 32'({o_E4, o_RW4}), 32'd0);
    stuck4 = 1'b0;
    wait_idle4(600, "t4_idle");
    check("t4_to_pulses", 32'(to_pulses4 - t0), 32'd1);
    check("t4_to_width", 32'(to_max4), 32'd1);
    check("t4_rd_pulses", 32'(rdp4 - r0), 32'd10);
    check("t4_wr_cnt", 32'(wr_log4.size() - n0), 32'd4);
    check("t4_next_hi", 32'(wr_log4[n0+2]), 32'h005);
    check("t4_next_lo", 32'(wr_log4[n0+3]), 32'h00C);

    // FIFO fill: lead command occupies the engine, then five pushes
    n0 = wr_log4.size();
    exp_bytes = '{8'h11, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    push4(1'b1, 8'h11, held);
    repeat (3) @(negedge sys_clk);
    for (int i = 1; i <= 5; i++) begin
      push4(1'b1, 8'(exp_bytes[i]), held);
      if (i == 3) check("t5_ready_after3", 32'(o_ready4), 32'd1);
      if (i == 4) check("t5_ready_after4", 32'(o_ready4), 32'd0);
      if (i == 5) check("t5_fifth_held", 32'(held > 0), 32'd1);
    end
    wait_idle4(2000, "t5_idle");
    check("t5_wr_cnt", 32'(wr_log4.size() - n0), 32'd12);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t5_byte%0d_hi", i), 32'(wr_log4[n0+2*i]),
            32'h100 | 32'((exp_bytes[i] >> 4) & 'hF));
      check($sformatf("t5_byte%0d_lo", i), 32'(wr_log4[n0+2*i+1]),
            32'h100 | 32'(exp_bytes[i] & 'hF));
    end

    // Reset in the middle of a write E pulse
    push4(1'b1, 8'h9C, held);
    k = 0;
    while (!(o_E4 && !o_RW4) && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    check("t6_in_w_ehi", 32'({o_E4, o_RW4}), 32'b10);
    rst_n4 = 1'b0;
    @(negedge sys_clk);
    check("t6_rst_outs", 32'({o_E4, o_idle4, o_ready4}), 32'b011);
    rst_n4 = 1'b1;
    n0 = wr_log4.size(); r0 = rdp4;
    repeat (100) @(negedge sys_clk);
    check("t6_no_writes", 32'(wr_log4.size() - n0), 32'd0);
    check("t6_no_reads", 32'(rdp4 - r0), 32'd0);
    check("t6_still_idle", 32'(o_idle4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
